hps_ps2_multi_tx: RTL and testbench
===================================

Name: hps_ps2_multi_tx

Overview:
Parametrised successor to the fixed keyboard/mouse PS/2 emulation in the HPS I/O path. It serves NCH independent PS/2 device channels, each with a configurable-depth byte FIFO and a serialiser. All channels share one PS/2 bit-clock divider. Over the fixed two-channel version it adds true full/empty detection, per-channel sticky overflow, a busy status, and pop-on-completion semantics. The HPS command decoder writes bytes in; the core consumes the ps2_clk/ps2_data pairs.

Parameters:
NCH, 2, number of PS/2 channels (1..8)
FIFO_BITS, 3, log2 of per-channel FIFO depth (depth = 2**FIFO_BITS)
PS2DIV, 1000, clk_sys cycles per half PS/2 bit period (>=2)
CHW, $clog2(NCH) min 1, width of channel index (localparam)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
wr  in  1  one-cycle byte write strobe
wr_ch  in  CHW  target channel for wr; values >= NCH are ignored
wr_data  in  8  byte to enqueue
ovf_clr  in  NCH  per-channel clear of the overflow flag
fifo_full  out  NCH  channel FIFO holds 2**FIFO_BITS bytes
fifo_empty  out  NCH  channel FIFO holds 0 bytes
overflow  out  NCH  sticky: a write was dropped because the FIFO was full
busy  out  NCH  serialiser state != IDLE
ps2_clk  out  NCH  emulated PS/2 clock line
ps2_data  out  NCH  emulated PS/2 data line
host_inhibit  in  NCH  present only with PS2_INHIBIT_EN

Behaviour:
- Reset values: divider count 0; phase 0; all states IDLE; pointers 0; ps2_clk all 1; ps2_data all 1; overflow 0; fifo_empty all 1; fifo_full 0; busy 0.
- Divider: the count runs 0..PS2DIV-1. At terminal count, phase toggles and the count wraps to 0. "tick" is a one-cycle pulse on the clk_sys cycle after phase goes 0->1. The bit period is 2*PS2DIV cycles.
- ps2_clk[i] = phase | (state[i]==IDLE). This is combinational from registers, so there are no glitches.
- FIFO:
  - Pointers are FIFO_BITS+1 wide. Empty = pointers equal. Full = MSBs differ and lower bits are equal.
  - A write to a full FIFO is dropped and sets overflow[i] the next cycle.
  - Fullness is evaluated before any same-cycle pop, so the write is still dropped.
  - Simultaneous ovf_clr and an overflow-setting write on the same channel: the set wins.
- Serialiser, per channel, all transitions only on tick:
  - IDLE: if FIFO is non-empty, load the head byte without popping, parity<=1, data<=0 (start bit), go to D0.
  - D0..D7: data<=shift[0]; shift right; toggle parity when the bit is 1. Data goes out LSB first.
  - PAR: data<=parity (odd parity).
  - STOP: data<=1.
  - DONE: pop the FIFO (rptr+1), data stays 1, go to IDLE.
  - Total frame is 12 ticks. The next frame can start on the tick after DONE.
- Popping only at DONE means the head byte is never lost on abort.
- Channels are fully independent and share only tick.
- Reset mid-frame: lines return to 1 immediately (asynchronous) and FIFO contents are discarded.

Optional Feature:
PS2_INHIBIT_EN
- Defined:
  - host_inhibit[i] high in IDLE blocks starting a frame.
  - High at a tick in D0..PAR aborts the frame: state<=IDLE, data<=1, no pop, so the byte is resent after release.
  - In STOP/DONE it is ignored, and the frame completes.
- Undefined: the port is absent and frames are never blocked.

Decomposition:
- Package hps_ps2_pkg holds:
  - the state enum (IDLE, D0..D7, PAR, STOP, DONE; 4 bits)
  - the frame-length constant 12
  - the start/stop bit-value constants
- Sub-module ps2_tx_chan holds one FIFO, its serialiser and its flags. It is instantiated NCH times in a generate loop.
- The divider and write demux stay in the top module.

Test Plan:
- Reset, no writes -> ps2_clk=all 1, ps2_data=all 1, fifo_empty=all 1, busy=0 indefinitely.
- PS2DIV=4, write 0xA5 to ch0 -> ch0 data at successive ticks is 0,1,0,1,0,0,1,0,1,1(parity),1(stop). ps2_clk toggles every 4 cycles while busy. ch1 stays idle-high.
- NCH=2, write 0x12 to ch0 and 0x34 to ch1 back-to-back -> both frames start on the same tick and each channel carries its own bits.
- FIFO_BITS=2, five writes to ch1 while a frame is still pending -> fourth write sets fifo_full=1, fifth write sets overflow[1]=1. Four frames are sent, then fifo_empty=1. ovf_clr[1] then clears overflow[1].
- wr_ch=3 with NCH=2 -> no FIFO changes and no overflow.
- PS2_INHIBIT_EN: assert host_inhibit[0] during D3 of 0x5A -> line returns high and busy=0. Release it, and a full 0x5A frame is resent from the start bit.

Source files
------------

// File: rtl/hps_ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hps_ps2_pkg
// Brief    : Shared serialiser state encoding and PS/2 frame constants.
// Revision : 1.0 - initial release
// ============================================================================
package hps_ps2_pkg;

    localparam int   FRAME_TICKS = 12;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    // Encoding is sequential so D0..D7 -> PAR advances by increment.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_D0   = 4'd1,
        ST_D1   = 4'd2,
        ST_D2   = 4'd3,
        ST_D3   = 4'd4,
        ST_D4   = 4'd5,
        ST_D5   = 4'd6,
        ST_D6   = 4'd7,
        ST_D7   = 4'd8,
        ST_PAR  = 4'd9,
        ST_STOP = 4'd10,
        ST_DONE = 4'(FRAME_TICKS - 1)
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/hps_ps2_multi_tx_chan.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx_chan
// Brief    : One PS/2 channel: byte FIFO, frame serialiser, status flags.
//            Optional macro PS2_INHIBIT_EN adds host_inhibit handling.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tx_chan
    import hps_ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick,
    input  logic       phase,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       ovf_clr,
`ifdef PS2_INHIBIT_EN
    input  logic       host_inhibit,
`endif
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int DEPTH = 2 ** FIFO_BITS;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_BITS:0] wptr;
    logic [FIFO_BITS:0] rptr;
    logic               push;
    logic               pop;
    logic               inhibit;
    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [7:0]         shift;
    logic [7:0]         shift_nxt;
    logic               parity;
    logic               parity_nxt;
    logic               data;
    logic               data_nxt;

`ifdef PS2_INHIBIT_EN
    assign inhibit = host_inhibit;
`else
    assign inhibit = 1'b0;
`endif

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                        (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
    assign push       = wr && !fifo_full;

    assign busy       = (state != ST_IDLE);
    assign ps2_clk    = phase | ~busy;
    assign ps2_data   = data;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wptr[FIFO_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + (FIFO_BITS+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (FIFO_BITS+1)'(1);
            end
            // A dropped write outranks a same-cycle clear.
            if (wr && fifo_full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            shift  <= '0;
            parity <= 1'b1;
            data   <= STOP_BIT;
        end else begin
            state  <= state_nxt;
            shift  <= shift_nxt;
            parity <= parity_nxt;
            data   <= data_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift;
        parity_nxt = parity;
        data_nxt   = data;
        pop        = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    // Head byte is only peeked; it leaves the FIFO at DONE.
                    if (!fifo_empty && !inhibit) begin
                        shift_nxt  = mem[rptr[FIFO_BITS-1:0]];
                        parity_nxt = 1'b1;
                        data_nxt   = START_BIT;
                        state_nxt  = ST_D0;
                    end
                end
                ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7: begin
                    data_nxt   = shift[0];
                    shift_nxt  = {1'b0, shift[7:1]};
                    parity_nxt = parity ^ shift[0];
                    state_nxt  = tx_state_t'(state + 4'd1);
                end
                ST_PAR: begin
                    data_nxt  = parity;
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    data_nxt  = STOP_BIT;
                    state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    pop       = 1'b1;
                    data_nxt  = STOP_BIT;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    data_nxt  = STOP_BIT;
                    state_nxt = ST_IDLE;
                end
            endcase
            if (inhibit && (state >= ST_D0) && (state <= ST_PAR)) begin
                data_nxt  = STOP_BIT;
                state_nxt = ST_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hps_ps2_multi_tx.sv
`default_nettype none
// ============================================================================
// Module   : hps_ps2_multi_tx
// Brief    : NCH-channel PS/2 device emulation sharing one bit-clock divider.
//            Optional macro PS2_INHIBIT_EN adds the host_inhibit input.
// Revision : 1.0 - initial release
// ============================================================================
module hps_ps2_multi_tx
    import hps_ps2_pkg::*;
#(
    parameter  int NCH       = 2,
    parameter  int FIFO_BITS = 3,
    parameter  int PS2DIV    = 1000,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           wr,
    input  logic [CHW-1:0] wr_ch,
    input  logic [7:0]     wr_data,
    input  logic [NCH-1:0] ovf_clr,
`ifdef PS2_INHIBIT_EN
    input  logic [NCH-1:0] host_inhibit,
`endif
    output logic [NCH-1:0] fifo_full,
    output logic [NCH-1:0] fifo_empty,
    output logic [NCH-1:0] overflow,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] ps2_clk,
    output logic [NCH-1:0] ps2_data
);

    localparam int              DIV_W    = $clog2(PS2DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PS2DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             phase;
    logic             tick;

    // tick fires on the cycle after phase rises, once per bit period.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                phase   <= ~phase;
                tick    <= ~phase;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic chan_wr;

        assign chan_wr = wr && (wr_ch == CHW'(i));

        ps2_tx_chan #(
            .FIFO_BITS (FIFO_BITS)
        ) u_chan (
            .clk_sys      (clk_sys),
            .reset        (reset),
            .tick         (tick),
            .phase        (phase),
            .wr           (chan_wr),
            .wr_data      (wr_data),
            .ovf_clr      (ovf_clr[i]),
`ifdef PS2_INHIBIT_EN
            .host_inhibit (host_inhibit[i]),
`endif
            .fifo_full    (fifo_full[i]),
            .fifo_empty   (fifo_empty[i]),
            .overflow     (overflow[i]),
            .busy         (busy[i]),
            .ps2_clk      (ps2_clk[i]),
            .ps2_data     (ps2_data[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_hps_ps2_multi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_ps2_multi_tx
// Brief    : Self-checking bench: frame decoder on the PS/2 lines plus a
//            byte-queue reference model per channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_ps2_multi_tx;

    localparam int NCH       = 3;
    localparam int FIFO_BITS = 2;
    localparam int PS2DIV    = 4;
    localparam int CHW       = 2;
    localparam int DEPTH     = 4;
    localparam int BITP      = 2 * PS2DIV;
    localparam logic [NCH-1:0] ALL1 = '1;

    logic           clk_sys;
    logic           reset;
    logic           wr;
    logic [CHW-1:0] wr_ch;
    logic [7:0]     wr_data;
    logic [NCH-1:0] ovf_clr;
    logic [NCH-1:0] fifo_full, fifo_empty, overflow, busy, ps2_clk, ps2_data;
`ifdef PS2_INHIBIT_EN
    logic [NCH-1:0] host_inhibit;
`endif

    hps_ps2_multi_tx #(.NCH(NCH), .FIFO_BITS(FIFO_BITS), .PS2DIV(PS2DIV)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .wr           (wr),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .ovf_clr      (ovf_clr),
`ifdef PS2_INHIBIT_EN
        .host_inhibit (host_inhibit),
`endif
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow),
        .busy         (busy),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc;
    always @(posedge clk_sys or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Line decoder: a bit is taken at every falling ps2_clk edge.
    logic [10:0] sh [NCH];
    int          nb [NCH];
    int          last_fall [NCH];
    int          first_fall [NCH];
    bit          ivl_ok [NCH];
    logic        prev_clk [NCH];
    int          cap_per_ch [NCH];
    int          abort_n [NCH];
    int          cap_n;
    logic [10:0] cap_bits [512];
    int          cap_ch [512];
    int          cap_start [512];
    bit          cap_ivl [512];

    always @(negedge clk_sys) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                nb[c] = 0; prev_clk[c] = 1'b1; cap_per_ch[c] = 0; abort_n[c] = 0; cap_n = 0;
            end else begin
                if (!busy[c] && nb[c] != 0) begin
                    abort_n[c]++;
                    nb[c] = 0;
                end
                if (prev_clk[c] && !ps2_clk[c]) begin
                    if (nb[c] == 0) begin
                        first_fall[c] = cyc;
                        ivl_ok[c] = 1'b1;
                    end else if (cyc - last_fall[c] != BITP) begin
                        ivl_ok[c] = 1'b0;
                    end
                    last_fall[c] = cyc;
                    sh[c][nb[c]] = ps2_data[c];
                    nb[c]++;
                    if (nb[c] == 11) begin
                        cap_bits[cap_n]  = sh[c];
                        cap_ch[cap_n]    = c;
                        cap_start[cap_n] = first_fall[c];
                        cap_ivl[cap_n]   = ivl_ok[c];
                        cap_n++;
                        cap_per_ch[c]++;
                        nb[c] = 0;
                    end
                end
                prev_clk[c] = ps2_clk[c];
            end
        end
    end

    // Reference model: ordered byte queue per channel.
    logic [7:0] exp_mem [NCH][128];
    int         exp_wr [NCH];
    int         exp_rd [NCH];
    int         chk_idx;
    int         n_cmp;
    int         n_fail;

    typedef struct packed {
        logic           wr;
        logic [CHW-1:0] ch;
        logic [7:0]     data;
        logic [NCH-1:0] clr;
        logic [NCH-1:0] exp_full;
        logic [NCH-1:0] exp_empty;
        logic [NCH-1:0] exp_ovf;
    } vec_t;
    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int pending(input int c);
        return exp_wr[c] - cap_per_ch[c];
    endfunction

    function automatic int exp_total();
        int s = 0;
        for (int c = 0; c < NCH; c++) s += exp_wr[c];
        return s;
    endfunction

    task automatic push_model(input int c, input logic [7:0] d);
        exp_mem[c][exp_wr[c]] = d;
        exp_wr[c]++;
    endtask

    task automatic do_write(input logic en, input int c, input logic [7:0] d, input logic [NCH-1:0] clr);
        @(negedge clk_sys);
        wr = en; wr_ch = CHW'(c); wr_data = d; ovf_clr = clr;
        if (en && c < NCH && pending(c) < DEPTH) push_model(c, d);
        @(negedge clk_sys);
        wr = 1'b0; ovf_clr = '0;
    endtask

    task automatic wait_frames(input int total);
        for (int k = 0; k < 6000 && cap_n < total; k++) @(negedge clk_sys);
        check("frames_seen", cap_n, total);
    endtask

    task automatic check_frames();
        logic [7:0] b;
        int c;
        for (; chk_idx < cap_n; chk_idx++) begin
            c = cap_ch[chk_idx];
            if (exp_rd[c] < exp_wr[c]) begin
                b = exp_mem[c][exp_rd[c]];
                exp_rd[c]++;
                check($sformatf("frame_ch%0d", c), cap_bits[chk_idx], {1'b1, ~^b, b, 1'b0});
                check($sformatf("bit_period_ch%0d", c), cap_ivl[chk_idx], 1);
            end else begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_frame_ch%0d: got 0x%0h, want none", c, cap_bits[chk_idx]);
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && !(busy == '0 && fifo_empty == ALL1); k++) @(negedge clk_sys);
        check("idle_busy", busy, 0);
        check("idle_empty", fifo_empty, ALL1);
        check("idle_full", fifo_full, 0);
    endtask

    initial begin
        int base;
        int c;
        logic [7:0] b;
        int exp_abort0;

        n_cmp = 0; n_fail = 0; chk_idx = 0; exp_abort0 = 0;
        for (int i = 0; i < NCH; i++) begin exp_wr[i] = 0; exp_rd[i] = 0; end
        reset = 1'b1; wr = 1'b0; wr_ch = '0; wr_data = '0; ovf_clr = '0;
`ifdef PS2_INHIBIT_EN
        host_inhibit = '0;
`endif
        // {wr, ch, data, clr, exp_full, exp_empty, exp_ovf}; ch 3 is out of range
        vt[0] = '{1'b1, 2'd1, 8'h11, 3'b000, 3'b000, 3'b101, 3'b000};
        vt[1] = '{1'b1, 2'd3, 8'hEE, 3'b000, 3'b000, 3'b101, 3'b000};
        vt[2] = '{1'b1, 2'd1, 8'h22, 3'b000, 3'b000, 3'b101, 3'b000};
        vt[3] = '{1'b1, 2'd1, 8'h33, 3'b000, 3'b000, 3'b101, 3'b000};
        vt[4] = '{1'b1, 2'd1, 8'h44, 3'b000, 3'b010, 3'b101, 3'b000};
        vt[5] = '{1'b1, 2'd1, 8'h55, 3'b000, 3'b010, 3'b101, 3'b010};
        vt[6] = '{1'b1, 2'd3, 8'h66, 3'b000, 3'b010, 3'b101, 3'b010};
        vt[7] = '{1'b1, 2'd1, 8'h77, 3'b010, 3'b010, 3'b101, 3'b010};
        vt[8] = '{1'b0, 2'd0, 8'h00, 3'b010, 3'b010, 3'b101, 3'b000};

        repeat (3) @(negedge clk_sys);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            repeat (9) @(negedge clk_sys);
            check("rst_ps2_clk", ps2_clk, ALL1);
            check("rst_ps2_data", ps2_data, ALL1);
            check("rst_empty", fifo_empty, ALL1);
            check("rst_full", fifo_full, 0);
            check("rst_ovf", overflow, 0);
            check("rst_busy", busy, 0);
        end

        // Single 0xA5 frame on ch0; other channels must stay high
        base = cap_n;
        do_write(1'b1, 0, 8'hA5, '0);
        for (int k = 0; k < 2000 && nb[0] != 5; k++) @(negedge clk_sys);
        check("a5_busy", busy, 3'b001);
        check("a5_others_clk", ps2_clk[2:1], 2'b11);
        check("a5_others_data", ps2_data[2:1], 2'b11);
        wait_frames(exp_total());
        check("a5_bits", cap_bits[base], 11'h74A);
        check_frames();
        wait_idle();

        // Two channels loaded between ticks must start together
        for (int k = 0; k < 16 && (cyc % BITP) != 5; k++) @(negedge clk_sys);
        base = cap_n;
        wr = 1'b1; wr_ch = 2'd0; wr_data = 8'h12; push_model(0, 8'h12);
        @(negedge clk_sys);
        wr_ch = 2'd1; wr_data = 8'h34; push_model(1, 8'h34);
        @(negedge clk_sys);
        wr = 1'b0;
        wait_frames(exp_total());
        check("same_start_tick", cap_start[base + 1], cap_start[base]);
        check_frames();
        wait_idle();

        // FIFO fill, overflow, out-of-range channel, clear priority
        for (int i = 0; i < 9; i++) begin
            do_write(vt[i].wr, int'(vt[i].ch), vt[i].data, vt[i].clr);
            check($sformatf("tbl%0d_full", i), fifo_full, vt[i].exp_full);
            check($sformatf("tbl%0d_empty", i), fifo_empty, vt[i].exp_empty);
            check($sformatf("tbl%0d_ovf", i), overflow, vt[i].exp_ovf);
        end
        wait_frames(exp_total());
        check_frames();
        wait_idle();

`ifdef PS2_INHIBIT_EN
        // Abort in D3, hold off while idle, then full resend
        do_write(1'b1, 0, 8'h5A, '0);
        for (int k = 0; k < 2000 && nb[0] != 4; k++) @(negedge clk_sys);
        check("inh_reach_d3", nb[0], 4);
        host_inhibit[0] = 1'b1;
        for (int k = 0; k < 40 && busy[0]; k++) @(negedge clk_sys);
        check("inh_abort_busy", busy[0], 0);
        check("inh_abort_data", ps2_data[0], 1);
        check("inh_abort_clk", ps2_clk[0], 1);
        repeat (4 * BITP) @(negedge clk_sys);
        check("inh_hold_busy", busy[0], 0);
        check("inh_hold_empty", fifo_empty[0], 0);
        exp_abort0 = 1;
        host_inhibit[0] = 1'b0;
        wait_frames(exp_total());
        check_frames();
        wait_idle();
`endif

        // Randomised traffic, never exceeding what the FIFO can hold
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk_sys);
            c = int'($urandom_range(0, 3));
            b = 8'($urandom);
            if (c >= NCH) do_write(1'b1, c, b, '0);
            else if (pending(c) < DEPTH - 1) do_write(1'b1, c, b, '0);
        end
        wait_frames(exp_total());
        check_frames();
        wait_idle();
        check("final_ovf", overflow, 0);
        check("abort_ch0", abort_n[0], exp_abort0);
        check("abort_ch1", abort_n[1], 0);
        check("abort_ch2", abort_n[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
